// File: rtl/seq_gen_pkg.sv
// ---------------------------------------------------------------------------
// seq_gen_pkg
// Shared definitions for the serial pattern generator:
//   - state_t      : controller states (2-bit encoding)
//   - DEF_*        : default parameter values for WIDTH / LEN_W / CNT_W / GAP_W
//   - clamp_len()  : limits a requested pattern length to the pattern width
// ---------------------------------------------------------------------------
package seq_gen_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_LEN_W = 4;
  localparam int DEF_CNT_W = 4;
  localparam int DEF_GAP_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    FIN  = 2'd3
  } state_t;

  // A request longer than the pattern register can only send what is stored,
  // so the length saturates at the register width.
  function automatic int unsigned clamp_len(input int unsigned req_len,
                                            input int unsigned max_len);
    return (req_len > max_len) ? max_len : req_len;
  endfunction

endpackage

// File: rtl/seq_down_counter.sv
// ---------------------------------------------------------------------------
// seq_down_counter
// Loadable down-counter with a zero flag. Load has priority over decrement,
// and decrementing stops at zero (never wraps).
// Ports:
//   clk       in   rising-edge clock
//   reset     in   synchronous active-high reset (count -> 0)
//   load      in   load load_val on the next edge
//   dec       in   decrement on the next edge (ignored when load=1 or at 0)
//   load_val  in   W-bit value to load
//   count     out  current count (registered)
//   zero      out  count == 0
// ---------------------------------------------------------------------------
module seq_down_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         zero
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - W'(1);
    end
  end

  assign count = count_reg;
  assign zero  = (count_reg == '0);

endmodule

// File: rtl/seq_pattern_gen.sv
// ---------------------------------------------------------------------------
// seq_pattern_gen
// Serial pattern transmitter. Sends the low `len` bits of `pattern`, MSB
// first, `repeat_n` times with `gap` idle cycles between repeats.
// Ports:
//   clk       in   rising-edge clock
//   reset     in   synchronous active-high reset
//   start     in   job request, accepted only in IDLE
//   abort     in   cancel a running job (SEND/GAP), no done pulse
//   pattern   in   WIDTH bits, bit len-1 sent first
//   len       in   bits per repeat (clamped to WIDTH)
//   repeat_n  in   number of repeats
//   gap       in   idle cycles between repeats
//   w         out  serial data (0 whenever valid=0)
//   valid     out  w carries a pattern bit
//   busy      out  job in progress (SEND or GAP)
//   done      out  one-cycle completion pulse
// All outputs are registered: the comb block computes the values for the
// next cycle, so the first bit appears the cycle after the start edge.
// ---------------------------------------------------------------------------
module seq_pattern_gen
  import seq_gen_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LEN_W = DEF_LEN_W,
  parameter int CNT_W = DEF_CNT_W,
  parameter int GAP_W = DEF_GAP_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic [CNT_W-1:0] repeat_n,
  input  logic [GAP_W-1:0] gap,
  output logic             w,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  state_t state_reg, state_next;

  // Job parameters captured at the start edge
  logic [WIDTH-1:0] pat_reg;
  logic [LEN_W-1:0] len_reg;
  logic [GAP_W-1:0] gap_reg;

  logic w_reg, w_next;
  logic valid_reg, valid_next;
  logic busy_reg, busy_next;
  logic done_reg, done_next;

  // Counter control
  logic             bit_load, bit_dec, bit_zero;
  logic [LEN_W-1:0] bit_load_val, bit_idx;
  logic             rep_load, rep_dec, rep_zero;
  logic [CNT_W-1:0] rep_load_val, rep_cnt;
  logic             gap_load, gap_dec, gap_zero;
  logic [GAP_W-1:0] gap_load_val, gap_cnt;

  // Bit selection via shifts keeps the index width independent of WIDTH
  logic [LEN_W-1:0] len_c, len_c_m1, len_reg_m1, bit_idx_m1;
  logic [WIDTH-1:0] start_shift, restart_shift, next_shift;
  logic             start_bit, restart_bit, next_bit;

  assign len_c       = LEN_W'(clamp_len(32'(len), WIDTH));
  assign len_c_m1    = len_c - LEN_W'(1);
  assign len_reg_m1  = len_reg - LEN_W'(1);
  assign bit_idx_m1  = bit_idx - LEN_W'(1);

  assign start_shift   = pattern >> len_c_m1;
  assign restart_shift = pat_reg >> len_reg_m1;
  assign next_shift    = pat_reg >> bit_idx_m1;
  assign start_bit     = start_shift[0];
  assign restart_bit   = restart_shift[0];
  assign next_bit      = next_shift[0];

  // Repeat and gap counters hold "remaining after the current one", so the
  // last repeat / last gap cycle is simply the zero flag.
  assign rep_load_val = repeat_n - CNT_W'(1);
  assign gap_load_val = gap_reg - GAP_W'(1);

  // Only the zero flags of the repeat and gap counters drive control
  logic unused_cnt_bits;
  assign unused_cnt_bits = ^{rep_cnt, gap_cnt};

  seq_down_counter #(.W(LEN_W)) u_bit_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (bit_load),
    .dec      (bit_dec),
    .load_val (bit_load_val),
    .count    (bit_idx),
    .zero     (bit_zero)
  );

  seq_down_counter #(.W(CNT_W)) u_rep_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (rep_load),
    .dec      (rep_dec),
    .load_val (rep_load_val),
    .count    (rep_cnt),
    .zero     (rep_zero)
  );

  seq_down_counter #(.W(GAP_W)) u_gap_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (gap_load),
    .dec      (gap_dec),
    .load_val (gap_load_val),
    .count    (gap_cnt),
    .zero     (gap_zero)
  );

  always_comb begin
    state_next   = state_reg;
    w_next       = 1'b0;
    valid_next   = 1'b0;
    busy_next    = 1'b0;
    done_next    = 1'b0;
    bit_load     = 1'b0;
    bit_dec      = 1'b0;
    bit_load_val = len_reg_m1;
    rep_load     = 1'b0;
    rep_dec      = 1'b0;
    gap_load     = 1'b0;
    gap_dec      = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          if ((len_c == '0) || (repeat_n == '0)) begin
            state_next = FIN;
            done_next  = 1'b1;
          end else begin
            state_next   = SEND;
            bit_load     = 1'b1;
            bit_load_val = len_c_m1;
            rep_load     = 1'b1;
            w_next       = start_bit;
            valid_next   = 1'b1;
            busy_next    = 1'b1;
          end
        end
      end

      SEND: begin
        if (abort) begin
          state_next = IDLE;
        end else if (!bit_zero) begin
          bit_dec    = 1'b1;
          w_next     = next_bit;
          valid_next = 1'b1;
          busy_next  = 1'b1;
        end else if (!rep_zero) begin
          rep_dec = 1'b1;
          if (gap_reg != '0) begin
            state_next = GAP;
            gap_load   = 1'b1;
            busy_next  = 1'b1;
          end else begin
            // Back-to-back repeat: reload and keep streaming with no bubble
            bit_load   = 1'b1;
            w_next     = restart_bit;
            valid_next = 1'b1;
            busy_next  = 1'b1;
          end
        end else begin
          state_next = FIN;
          done_next  = 1'b1;
        end
      end

      GAP: begin
        if (abort) begin
          state_next = IDLE;
        end else if (gap_zero) begin
          state_next = SEND;
          bit_load   = 1'b1;
          w_next     = restart_bit;
          valid_next = 1'b1;
          busy_next  = 1'b1;
        end else begin
          gap_dec   = 1'b1;
          busy_next = 1'b1;
        end
      end

      FIN: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      w_reg     <= 1'b0;
      valid_reg <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      pat_reg   <= '0;
      len_reg   <= '0;
      gap_reg   <= '0;
    end else begin
      state_reg <= state_next;
      w_reg     <= w_next;
      valid_reg <= valid_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      if ((state_reg == IDLE) && start) begin
        pat_reg <= pattern;
        len_reg <= len_c;
        gap_reg <= gap;
      end
    end
  end

  assign w     = w_reg;
  assign valid = valid_reg;
  assign busy  = busy_reg;
  assign done  = done_reg;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// ---------------------------------------------------------------------------
// tb_seq_pattern_gen
// Directed bench for seq_pattern_gen. Each cycle compares the observed
// {w, valid, busy, done} against hand-computed values.
// ---------------------------------------------------------------------------
module tb_seq_pattern_gen;

  logic       clk = 1'b0;
  logic       reset, start, abort;
  logic [7:0] pattern;
  logic [3:0] len, repeat_n;
  logic [2:0] gap;
  logic       w, valid, busy, done;

  int checks = 0;
  int passes = 0;

  seq_pattern_gen dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .abort    (abort),
    .pattern  (pattern),
    .len      (len),
    .repeat_n (repeat_n),
    .gap      (gap),
    .w        (w),
    .valid    (valid),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present a job and pulse start for one edge; returns 1ns after that edge
  task automatic launch(input logic [7:0] p, input logic [3:0] l,
                        input logic [3:0] r, input logic [2:0] g);
    pattern  = p;
    len      = l;
    repeat_n = r;
    gap      = g;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    pattern = 8'hFF; len = 4'd4; repeat_n = 4'd1; gap = 3'd0;
    tick(); tick();
    checks++;
    if ({w, valid, busy, done} !== 4'b0000)
      $display("FAIL reset: got w/valid/busy/done=%b expected 0000", {w, valid, busy, done});
    else passes++;
    reset = 1'b0;
    tick();
    checks++;
    if ({w, valid, busy, done} !== 4'b0000)
      $display("FAIL reset_release: got %b expected 0000", {w, valid, busy, done});
    else passes++;
  endtask

  task automatic test_single;
    logic [3:0] ew;
    ew = 4'b1011;
    launch(8'b0000_1011, 4'd4, 4'd1, 3'd0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({w, valid, busy, done} !== {ew[3-i], 3'b110})
        $display("FAIL single bit%0d: got %b expected %b", i, {w, valid, busy, done}, {ew[3-i], 3'b110});
      else passes++;
      tick();
    end
    checks++;
    if ({w, valid, busy, done} !== 4'b0001)
      $display("FAIL single done: got %b expected 0001", {w, valid, busy, done});
    else passes++;
    tick();
    checks++;
    if ({w, valid, busy, done} !== 4'b0000)
      $display("FAIL single idle: got %b expected 0000", {w, valid, busy, done});
    else passes++;
  endtask

  task automatic test_gap;
    logic [9:0] ew, ev;
    ew = 10'b1011_00_1011;
    ev = 10'b1111_00_1111;
    launch(8'b0000_1011, 4'd4, 4'd2, 3'd2);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({w, valid, busy, done} !== {ew[9-i], ev[9-i], 2'b10})
        $display("FAIL gap cyc%0d: got %b expected %b", i, {w, valid, busy, done}, {ew[9-i], ev[9-i], 2'b10});
      else passes++;
      tick();
    end
    checks++;
    if ({w, valid, busy, done} !== 4'b0001)
      $display("FAIL gap done: got %b expected 0001", {w, valid, busy, done});
    else passes++;
    tick();
  endtask

  task automatic test_back_to_back;
    logic [8:0] ew;
    logic [2:0] ew2;
    ew  = 9'b110_110_110;
    ew2 = 3'b011;
    launch(8'b0000_0110, 4'd3, 4'd3, 3'd0);
    for (int i = 0; i < 9; i++) begin
      checks++;
      if ({w, valid, busy, done} !== {ew[8-i], 3'b110})
        $display("FAIL b2b cyc%0d: got %b expected %b", i, {w, valid, busy, done}, {ew[8-i], 3'b110});
      else passes++;
      tick();
    end
    // start held through FIN must be ignored there, then accepted in IDLE
    pattern = 8'b0000_1011; len = 4'd4; repeat_n = 4'd1; gap = 3'd0;
    start = 1'b1;
    checks++;
    if ({w, valid, busy, done} !== 4'b0001)
      $display("FAIL b2b done: got %b expected 0001", {w, valid, busy, done});
    else passes++;
    tick();
    checks++;
    if ({w, valid, busy, done} !== 4'b0000)
      $display("FAIL start_in_fin: got %b expected 0000", {w, valid, busy, done});
    else passes++;
    tick();
    start = 1'b0;
    checks++;
    if ({w, valid, busy, done} !== 4'b1110)
      $display("FAIL start_after_fin: got %b expected 1110", {w, valid, busy, done});
    else passes++;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({w, valid, busy, done} !== {ew2[2-i], 3'b110})
        $display("FAIL after_fin bit%0d: got %b expected %b", i + 1, {w, valid, busy, done}, {ew2[2-i], 3'b110});
      else passes++;
    end
    tick();
    checks++;
    if ({w, valid, busy, done} !== 4'b0001)
      $display("FAIL after_fin done: got %b expected 0001", {w, valid, busy, done});
    else passes++;
    tick();
  endtask

  task automatic test_degenerate;
    launch(8'hFF, 4'd0, 4'd2, 3'd1);
    checks++;
    if ({w, valid, busy, done} !== 4'b0001)
      $display("FAIL len0 done: got %b expected 0001", {w, valid, busy, done});
    else passes++;
    tick();
    checks++;
    if ({w, valid, busy, done} !== 4'b0000)
      $display("FAIL len0 idle: got %b expected 0000", {w, valid, busy, done});
    else passes++;
    launch(8'hFF, 4'd3, 4'd0, 3'd0);
    checks++;
    if ({w, valid, busy, done} !== 4'b0001)
      $display("FAIL rep0 done: got %b expected 0001", {w, valid, busy, done});
    else passes++;
    tick();
  endtask

  task automatic test_clamp;
    logic [7:0] ew;
    ew = 8'b1000_0001;
    launch(8'h81, 4'd15, 4'd1, 3'd0);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({w, valid, busy, done} !== {ew[7-i], 3'b110})
        $display("FAIL clamp bit%0d: got %b expected %b", i, {w, valid, busy, done}, {ew[7-i], 3'b110});
      else passes++;
      tick();
    end
    checks++;
    if ({w, valid, busy, done} !== 4'b0001)
      $display("FAIL clamp done: got %b expected 0001", {w, valid, busy, done});
    else passes++;
    tick();
  endtask

  task automatic test_max_repeat;
    int nvalid;
    nvalid = 0;
    launch(8'h01, 4'd1, 4'd15, 3'd0);
    for (int i = 0; i < 15; i++) begin
      if ({w, valid, busy, done} === 4'b1110) nvalid++;
      tick();
    end
    checks++;
    if (nvalid != 15)
      $display("FAIL max_repeat count: got %0d expected 15", nvalid);
    else passes++;
    checks++;
    if ({w, valid, busy, done} !== 4'b0001)
      $display("FAIL max_repeat done: got %b expected 0001", {w, valid, busy, done});
    else passes++;
    tick();
  endtask

  task automatic test_start_busy;
    logic [3:0] ew;
    ew = 4'b1011;
    launch(8'b0000_1011, 4'd4, 4'd1, 3'd0);
    for (int i = 0; i < 4; i++) begin
      if (i == 0) begin
        start = 1'b1; pattern = 8'hF0; len = 4'd2; repeat_n = 4'd3;
      end
      if (i == 3) start = 1'b0;
      checks++;
      if ({w, valid, busy, done} !== {ew[3-i], 3'b110})
        $display("FAIL start_busy bit%0d: got %b expected %b", i, {w, valid, busy, done}, {ew[3-i], 3'b110});
      else passes++;
      tick();
    end
    checks++;
    if ({w, valid, busy, done} !== 4'b0001)
      $display("FAIL start_busy done: got %b expected 0001", {w, valid, busy, done});
    else passes++;
    tick();
  endtask

  task automatic test_abort;
    logic [3:0] ew;
    ew = 4'b1011;
    launch(8'b0000_1011, 4'd4, 4'd1, 3'd0);
    tick(); tick();
    checks++;
    if ({w, valid, busy, done} !== 4'b1110)
      $display("FAIL abort third_bit: got %b expected 1110", {w, valid, busy, done});
    else passes++;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({w, valid, busy, done} !== 4'b0000)
        $display("FAIL abort idle%0d: got %b expected 0000", i, {w, valid, busy, done});
      else passes++;
      tick();
    end
    launch(8'b0000_1011, 4'd4, 4'd1, 3'd0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({w, valid, busy, done} !== {ew[3-i], 3'b110})
        $display("FAIL abort restart bit%0d: got %b expected %b", i, {w, valid, busy, done}, {ew[3-i], 3'b110});
      else passes++;
      tick();
    end
    checks++;
    if ({w, valid, busy, done} !== 4'b0001)
      $display("FAIL abort restart done: got %b expected 0001", {w, valid, busy, done});
    else passes++;
    tick();
  endtask

  task automatic test_reset_mid;
    logic [7:0] ew;
    ew = 8'b1010_0101;
    launch(8'b0000_1011, 4'd4, 4'd2, 3'd2);
    tick(); tick(); tick(); tick();
    checks++;
    if ({w, valid, busy, done} !== 4'b0010)
      $display("FAIL reset_mid in_gap: got %b expected 0010", {w, valid, busy, done});
    else passes++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({w, valid, busy, done} !== 4'b0000)
        $display("FAIL reset_mid idle%0d: got %b expected 0000", i, {w, valid, busy, done});
      else passes++;
      tick();
    end
    launch(8'hA5, 4'd8, 4'd1, 3'd0);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({w, valid, busy, done} !== {ew[7-i], 3'b110})
        $display("FAIL reset_mid A5 bit%0d: got %b expected %b", i, {w, valid, busy, done}, {ew[7-i], 3'b110});
      else passes++;
      tick();
    end
    checks++;
    if ({w, valid, busy, done} !== 4'b0001)
      $display("FAIL reset_mid A5 done: got %b expected 0001", {w, valid, busy, done});
    else passes++;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_gap();
    test_back_to_back();
    test_degenerate();
    test_clamp();
    test_max_repeat();
    test_start_busy();
    test_abort();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
